// File: rtl/game_sequencer.sv
// Phase/level/lives sequencer for the symbol-counting game: PRE -> GAME -> ANSWER -> POST,
// timed by a synchronised 1 Hz tick, judging the Score difference at the end of POST.
module game_sequencer #(
  parameter int NUM_LEVELS = 8,
  parameter int LEVEL_W    = 4,
  parameter int PRE_SECS   = 3,
  parameter int GAME_SECS  = 10,
  parameter int ANS_SECS   = 10,
  parameter int POST_SECS  = 3,
  parameter int LIVES      = 3,
  parameter int TOL_BASE   = 2,
  parameter int DIFF_W     = 5
) (
  input  logic               Clk100M,
  input  logic               reset,
  input  logic               Clk1Hz,
  input  logic               start,
  input  logic [DIFF_W-1:0]  difference,
  input  logic               diffValid,
  output logic               prelimSig,
  output logic               gameSig,
  output logic               answerSig,
  output logic               postSig,
  output logic [2:0]         curPhase,
  output logic [7:0]         secsLeft,
  output logic [LEVEL_W-1:0] curLevel,
  output logic [3:0]         livesLeft,
  output logic               levelPass,
  output logic               lose,
  output logic               win
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRE    = 3'd1,
    GAME   = 3'd2,
    ANSWER = 3'd3,
    POST   = 3'd4,
    OVER   = 3'd5,
    WIN    = 3'd6
  } phase_t;

  phase_t              state;
  logic [2:0]          sync_q;
  logic                tick;
  logic                got_diff;
  logic [DIFF_W-1:0]   diff_q;
  logic [DIFF_W-1:0]   eff_diff;
  logic [31:0]         half_level;
  logic [31:0]         tol;
  logic                pass;
  logic                last_sec;
  logic                timed;

  assign curPhase = state;

  // Two flops resynchronise Clk1Hz; the third is the previous-value flop for edge detect.
  always_ff @(posedge Clk100M or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      tick   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
      sync_q <= {sync_q[1:0], Clk1Hz};
      tick   <= sync_q[1] & ~sync_q[2];
    end
  end

  always_comb begin
    half_level = 32'(curLevel) >> 1;
    tol        = (32'(TOL_BASE) > half_level) ? 32'(TOL_BASE) - half_level : '0;
    // A strobe landing on the judging edge supersedes the latched value.
    eff_diff   = diffValid ? difference : diff_q;
    pass       = (got_diff || diffValid) && (32'(eff_diff) <= tol);
    timed      = (state == PRE) || (state == GAME) || (state == ANSWER) || (state == POST);
    last_sec   = tick && (secsLeft == 8'd1);
  end

  always_ff @(posedge Clk100M or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      prelimSig <= 1'b0;
      gameSig   <= 1'b0;
      answerSig <= 1'b0;
      postSig   <= 1'b0;
      levelPass <= 1'b0;
      secsLeft  <= '0;
      curLevel  <= '0;
      livesLeft <= 4'(LIVES);
      lose      <= 1'b0;
      win       <= 1'b0;
      got_diff  <= 1'b0;
      diff_q    <= '0;
    end else begin
      prelimSig <= 1'b0;
      gameSig   <= 1'b0;
      answerSig <= 1'b0;
      postSig   <= 1'b0;
      levelPass <= 1'b0;

      // NOTE: the latch sits before the case so a PRE entry on the same edge wins and clears got_diff.
      if (diffValid && (state == ANSWER || state == POST)) begin
        diff_q   <= difference;
        got_diff <= 1'b1;
      end

      if (timed && tick && secsLeft > 8'd1) secsLeft <= secsLeft - 8'd1;

      unique case (state)
        IDLE, OVER, WIN: if (start) begin
          curLevel  <= '0;
          livesLeft <= 4'(LIVES);
          lose      <= 1'b0;
          win       <= 1'b0;
          state     <= PRE;
          secsLeft  <= 8'(PRE_SECS);
          prelimSig <= 1'b1;
          got_diff  <= 1'b0;
        end
        PRE: if (last_sec) begin
          state    <= GAME;
          secsLeft <= 8'(GAME_SECS);
          gameSig  <= 1'b1;
        end
        GAME: if (last_sec) begin
          state     <= ANSWER;
          secsLeft  <= 8'(ANS_SECS);
          answerSig <= 1'b1;
        end
        ANSWER: if (last_sec) begin
          state    <= POST;
          secsLeft <= 8'(POST_SECS);
          postSig  <= 1'b1;
        end
        POST: if (last_sec) begin
          if (pass && curLevel == LEVEL_W'(NUM_LEVELS - 1)) begin
            levelPass <= 1'b1;
            state     <= WIN;
            win       <= 1'b1;
            secsLeft  <= '0;
          end else if (pass || livesLeft > 4'd1) begin
            if (pass) begin
              levelPass <= 1'b1;
              curLevel  <= curLevel + LEVEL_W'(1);
            end else begin
              livesLeft <= livesLeft - 4'd1;
            end
            state     <= PRE;
            secsLeft  <= 8'(PRE_SECS);
            prelimSig <= 1'b1;
            got_diff  <= 1'b0;
          end else begin
            livesLeft <= '0;
            state     <= OVER;
            lose      <= 1'b1;
            secsLeft  <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          secsLeft <= '0;
        end
      endcase
    end
  end

endmodule
